// File: rtl/cpu_pkg.sv
// Shared widths, opcodes, instruction field positions and FSM encoding
// for the ALU issue/writeback controller.
package cpu_pkg;

    localparam int DW   = 12;
    localparam int NREG = 8;
    localparam int AW   = 3;
    localparam int IW   = 12;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_XOR = 3'b001;

    localparam int OP_HI  = 11;
    localparam int OP_LO  = 9;
    localparam int RD_HI  = 8;
    localparam int RD_LO  = 6;
    localparam int RS1_HI = 5;
    localparam int RS1_LO = 3;
    localparam int RS2_HI = 2;
    localparam int RS2_LO = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } state_t;

endpackage

// File: rtl/regfile_8x12.sv
// 8x12 register file: two combinational operand reads, a debug read and one
// write port shared between the host load and the writeback path.
module regfile_8x12 #(
    parameter int DW   = 12,
    parameter int NREG = 8,
    parameter int AW   = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_ld_en,
    input  logic [AW-1:0] i_ld_addr,
    input  logic [DW-1:0] i_ld_data,
    input  logic          i_wb_en,
    input  logic [AW-1:0] i_wb_addr,
    input  logic [DW-1:0] i_wb_data,
    input  logic [AW-1:0] i_raddr1,
    output logic [DW-1:0] o_rdata1,
    input  logic [AW-1:0] i_raddr2,
    output logic [DW-1:0] o_rdata2,
    input  logic [AW-1:0] i_dbg_addr,
    output logic [DW-1:0] o_dbg_data
);

    logic [NREG-1:0][DW-1:0] r_mem;
    logic                    w_we;
    logic [AW-1:0]           w_waddr;
    logic [DW-1:0]           w_wdata;

    // Writeback wins; the controller only enables loads in IDLE so both never collide.
    always_comb begin
        w_we    = i_wb_en | i_ld_en;
        w_waddr = i_wb_en ? i_wb_addr : i_ld_addr;
        w_wdata = i_wb_en ? i_wb_data : i_ld_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_mem <= '0;
        else if (w_we)
            r_mem[w_waddr] <= w_wdata;
    end

    assign o_rdata1   = r_mem[i_raddr1];
    assign o_rdata2   = r_mem[i_raddr2];
    assign o_dbg_data = r_mem[i_dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Four-state issue controller: accept, read operands into the ALU input
// registers, capture the external ALU result, write it back and pulse done.
module alu_issue_ctrl #(
    parameter int DW   = cpu_pkg::DW,
    parameter int NREG = cpu_pkg::NREG
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   instr_valid,
    input  logic [cpu_pkg::IW-1:0] instr,
    output logic                   instr_ready,
    input  logic                   ld_en,
    input  logic [cpu_pkg::AW-1:0] ld_addr,
    input  logic [DW-1:0]          ld_data,
    output logic [2:0]             alu_op,
    output logic [DW-1:0]          alu_op1,
    output logic [DW-1:0]          alu_op2,
    input  logic [DW-1:0]          alu_out,
    output logic                   done,
    output logic [DW-1:0]          result,
    output logic [cpu_pkg::AW-1:0] result_rd,
    input  logic [cpu_pkg::AW-1:0] dbg_addr,
    output logic [DW-1:0]          dbg_data
);
    import cpu_pkg::*;

    state_t          r_state;
    logic [2:0]      r_op;
    logic [AW-1:0]   r_rd, r_rs1, r_rs2;
    logic [2:0]      r_alu_op;
    logic [DW-1:0]   r_op1, r_op2, r_cap, r_result;
    logic [AW-1:0]   r_result_rd;
    logic            r_done;
    logic [DW-1:0]   w_rdata1, w_rdata2;
    logic            w_hs, w_ld_we, w_wb_we;

    // Ready is gated by rst so nothing is offered while the block is held in reset.
    assign instr_ready = (r_state == IDLE) && !rst;
    assign w_hs        = instr_valid && instr_ready;
    assign w_ld_we     = ld_en && (r_state == IDLE);
    assign w_wb_we     = (r_state == WB);

    regfile_8x12 #(.DW(DW), .NREG(NREG), .AW(AW)) u_rf (
        .clk        (clk),
        .rst        (rst),
        .i_ld_en    (w_ld_we),
        .i_ld_addr  (ld_addr),
        .i_ld_data  (ld_data),
        .i_wb_en    (w_wb_we),
        .i_wb_addr  (r_rd),
        .i_wb_data  (r_cap),
        .i_raddr1   (r_rs1),
        .o_rdata1   (w_rdata1),
        .i_raddr2   (r_rs2),
        .o_rdata2   (w_rdata2),
        .i_dbg_addr (dbg_addr),
        .o_dbg_data (dbg_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_op        <= '0;
            r_rd        <= '0;
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_alu_op    <= '0;
            r_op1       <= '0;
            r_op2       <= '0;
            r_cap       <= '0;
            r_result    <= '0;
            r_result_rd <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: if (w_hs) begin
                    r_op    <= instr[OP_HI:OP_LO];
                    r_rd    <= instr[RD_HI:RD_LO];
                    r_rs1   <= instr[RS1_HI:RS1_LO];
                    r_rs2   <= instr[RS2_HI:RS2_LO];
                    r_state <= READ;
                end
                READ: begin
                    r_alu_op <= r_op;
                    r_op1    <= w_rdata1;
                    r_op2    <= w_rdata2;
                    r_state  <= EXEC;
                end
                EXEC: begin
                    r_cap   <= alu_out;
                    r_state <= WB;
                end
                WB: begin
                    r_result    <= r_cap;
                    r_result_rd <= r_rd;
                    r_done      <= 1'b1;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign alu_op    = r_alu_op;
    assign alu_op1   = r_op1;
    assign alu_op2   = r_op2;
    assign done      = r_done;
    assign result    = r_result;
    assign result_rd = r_result_rd;

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Multicycle issue/writeback controller placed directly upstream of the 12-bit combinational `alu` (ports op[2:0], op1[11:0], op2[11:0], out[11:0]).
- Accepts 12-bit register-register instructions over a valid/ready handshake and reads both operands from an internal 8x12 register file.
- Drives the ALU inputs, captures the ALU output and writes it back to the destination register, then reports completion.
- A host load port preloads registers while the controller is idle.

Parameters:
- DW, 12, data/ALU width
- NREG, 8, register count (address width = 3)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- instr_valid  in  1  instruction offered
- instr  in  12  [11:9] op, [8:6] rd, [5:3] rs1, [2:0] rs2
- instr_ready  out  1  controller can accept an instruction
- ld_en  in  1  host register write request
- ld_addr  in  3  host write address
- ld_data  in  12  host write data
- alu_op  out  3  to alu.op
- alu_op1  out  12  to alu.op1
- alu_op2  out  12  to alu.op2
- alu_out  in  12  from alu.out
- done  out  1  one-cycle completion pulse
- result  out  12  last written-back value
- result_rd  out  3  last destination register
- dbg_addr  in  3  debug read address
- dbg_data  out  12  combinational read of regfile[dbg_addr]

Behaviour:
- Reset (async, active-high):
  - state = IDLE; all registers = 0.
  - alu_op, alu_op1, alu_op2, result, result_rd = 0; done = 0; instr_ready = 1 once rst deasserts.
- FSM states: IDLE, READ, EXEC, WB.
  - IDLE: instr_ready = 1. On instr_valid & instr_ready, latch op, rd, rs1 and rs2, then go to READ.
  - READ: load alu_op1 = reg[rs1], alu_op2 = reg[rs2] and alu_op = op into output registers. Go to EXEC.
  - EXEC: ALU inputs are stable; capture alu_out into an internal result register on this edge. Go to WB.
  - WB: write reg[rd] = captured value; result and result_rd update; done = 1 for exactly this cycle. Return to IDLE.
- Latency and throughput:
  - Handshake at edge N, then READ at N+1, EXEC at N+2, WB at N+3; done is high in the cycle following edge N+3.
  - Throughput is one instruction per 4 cycles.
  - instr_ready is 0 in READ, EXEC and WB.
- Read-after-write: an instruction accepted in the same edge that a WB write completes sees the new value, because READ occurs one cycle later.
- alu_op, alu_op1 and alu_op2 hold their values outside READ; they change only in READ.
- ALU result width is DW. No carry or flags are kept, and values are truncated to 12 bits.
- Host load port:
  - ld_en is honoured only in IDLE.
  - If ld_en and an instruction handshake happen in the same cycle, the load is performed and the instruction is still accepted; READ sees the loaded value.
  - ld_en outside IDLE is ignored (dropped, not queued).
- rd may equal rs1 or rs2: operands are read before writeback, so the old value is used.
- All 8 registers are writable; there is no hard-wired zero.
- Reset asserted mid-operation aborts the instruction immediately: no writeback, no done, and the regfile is cleared.
- dbg_data is purely combinational from the regfile and reflects a WB write the cycle after the write edge.

Decomposition:
- Shared package `cpu_pkg`:
  - DW, NREG and the 3-bit ALU opcode localparams.
  - Instruction field bit positions (OP_HI/LO, RD_HI/LO, RS1_HI/LO, RS2_HI/LO).
  - FSM state encoding (IDLE = 2'd0, READ = 2'd1, EXEC = 2'd2, WB = 2'd3).
- One natural sub-module: `regfile_8x12`. It has 2 combinational read ports plus a debug read, and 1 write port with a mux between ld and WB. The controller FSM stays in alu_issue_ctrl.

Test Plan:
The bench models the ALU as out = op1 + op2 when op = 3'b000 and out = op1 ^ op2 otherwise, computed combinationally from alu_op1 and alu_op2.
- Reset: assert rst mid-cycle (asynchronous) -> all outputs 0 immediately; all 8 dbg_data reads = 0; instr_ready = 1 after release.
- Basic add:
  - Stimulus: ld r1 = 12'h0F0, r2 = 12'h00F; instr = {3'b000, 3'd3, 3'd1, 3'd2}.
  - Required response: alu_op1 = 12'h0F0, alu_op2 = 12'h00F, done pulses 4 cycles after the handshake, result = 12'h0FF, result_rd = 3, dbg r3 = 12'h0FF.
- Wrap and overlap:
  - Stimulus: r4 = 12'hFFF, r5 = 12'h001; instr {000, 4, 4, 5}.
  - Required response: result = 12'h000 (truncated); r4 = 0; r5 unchanged.
- Back-to-back dependency:
  - Stimulus: XOR {001, 6, 1, 2} followed immediately by {000, 7, 6, 6}.
  - Required response: r6 = 12'h0FF, r7 = 12'h1FE; instr_ready low for exactly 3 cycles after each handshake.
- Load arbitration: ld_en with ld_addr = 1 asserted during EXEC -> ignored, r1 unchanged. The same load applied in IDLE together with a handshake -> the instruction uses the new r1.
- Abort: assert rst during EXEC -> done never pulses, rd not written, FSM in IDLE, regfile all 0.
